// File: rtl/sprite_blitter.sv
// Sprite overlay stage for the VGA pixel pipeline: positioned, scaled, flippable, animated
// sprite composited over the background via colour-key transparency, fixed 2-cycle latency.
module sprite_blitter #(
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int FRAMES          = 4,
  parameter int SCALE_SHIFT     = 1,
  parameter int IDX_W           = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ANIM_DIV        = 8,
  parameter int ADDR_W          = $clog2(FRAMES*SPRITE_W*SPRITE_H)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              anim_en,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_on
);

  localparam int BOX_W    = SPRITE_W << SCALE_SHIFT;
  localparam int BOX_H    = SPRITE_H << SCALE_SHIFT;
  localparam int FRAME_SZ = SPRITE_W * SPRITE_H;
  localparam int FIDX_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  logic [9:0]        px, py;
  logic              flip;
  logic [FIDX_W-1:0] fidx;
  logic [DIV_W-1:0]  div;

  // Shadow state only moves on frame_start so a frame is always drawn from one snapshot.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      px   <= '0;
      py   <= '0;
      flip <= 1'b0;
      fidx <= '0;
      div  <= '0;
    end else if (frame_start) begin
      px   <= pos_x;
      py   <= pos_y;
      flip <= flip_h;
      if (anim_en) begin
        if (div == DIV_W'(ANIM_DIV-1)) begin
          div  <= '0;
          fidx <= (fidx == FIDX_W'(FRAMES-1)) ? '0 : fidx + 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

  // Stage 0: 11-bit differences; the sign bit rejects pixels left/above the sprite, so no wrap.
  logic [10:0] dx, dy;
  logic [9:0]  lx, ly, lxf;
  logic        hit0;

  always_comb begin
    dx   = {1'b0, DrawX} - {1'b0, px};
    dy   = {1'b0, DrawY} - {1'b0, py};
    hit0 = !dx[10] && (dx[9:0] < 10'(BOX_W)) && !dy[10] && (dy[9:0] < 10'(BOX_H));
    lx   = dx[9:0] >> SCALE_SHIFT;
    ly   = dy[9:0] >> SCALE_SHIFT;
    lxf  = flip ? 10'(SPRITE_W-1) - lx : lx;
    rom_addr = '0;
    if (hit0)
      rom_addr = ADDR_W'(fidx) * ADDR_W'(FRAME_SZ) + ADDR_W'(ly) * ADDR_W'(SPRITE_W)
               + ADDR_W'(lxf);
  end

  assign pal_index = rom_q;

  // Stage 1 aligns hit and background with the ROM's registered read.
  logic hit1, opaque;
  rgb_t bg1;

  assign opaque = hit1 && (rom_q != IDX_W'(TRANSPARENT_IDX));

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hit1      <= 1'b0;
      bg1       <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      sprite_on <= 1'b0;
    end else begin
      hit1      <= hit0;
      bg1       <= '{r: bg_red, g: bg_green, b: bg_blue};
      red       <= opaque ? pal_red   : bg1.r;
      green     <= opaque ? pal_green : bg1.g;
      blue      <= opaque ? pal_blue  : bg1.b;
      sprite_on <= opaque;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: stimulus queues expected pixels/values,
// a negedge monitor pops and compares them.
module tb_sprite_blitter;

  localparam int AW = 12;

  logic          vga_clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic [9:0]    DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic          flip_h = 1'b0, anim_en = 1'b0;
  logic [3:0]    bg_red = '0, bg_green = '0, bg_blue = '0;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_q = '0;
  logic [3:0]    pal_index, pal_red, pal_green, pal_blue;
  logic [3:0]    red, green, blue;
  logic          sprite_on;

  logic [3:0] rom_val = 4'd5;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int t; int x; int y;
    logic [3:0] r; logic [3:0] g; logic [3:0] b; logic on;
  } exp_t;
  typedef struct {int tag; int x; int y; int act; int exp;} dir_t;

  exp_t sb[$];
  dir_t dq[$];

  sprite_blitter dut (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
    .flip_h(flip_h), .anim_en(anim_en),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .sprite_on(sprite_on)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM returning a programmable constant index; simple palette.
  always @(posedge vga_clk) begin
    cyc   <= cyc + 1;
    rom_q <= rom_val;
  end
  assign pal_red   = pal_index;
  assign pal_green = ~pal_index;
  assign pal_blue  = pal_index + 4'd3;

  function automatic string tag_name(input int tag);
    case (tag)
      0: return "reset_red";
      1: return "reset_green";
      2: return "reset_blue";
      3: return "reset_sprite_on";
      4: return "rom_addr";
      default: return "pre_reset_sprite_on";
    endcase
  endfunction

  always @(negedge vga_clk) begin
    exp_t e;
    dir_t d;
    while (dq.size() > 0) begin
      d = dq.pop_front();
      n_chk++;
      if (d.act != d.exp) begin
        n_err++;
        $display("FAIL %s at (%0d,%0d): got %0d want %0d", tag_name(d.tag), d.x, d.y, d.act, d.exp);
      end
    end
    while (sb.size() > 0 && sb[0].t < cyc) begin
      e = sb.pop_front();
      n_chk++;
      n_err++;
      $display("FAIL pixel (%0d,%0d): output never sampled, want rgb=%h%h%h on=%b",
               e.x, e.y, e.r, e.g, e.b, e.on);
    end
    if (sb.size() > 0 && sb[0].t == cyc) begin
      e = sb.pop_front();
      n_chk++;
      if ({red, green, blue, sprite_on} !== {e.r, e.g, e.b, e.on}) begin
        n_err++;
        $display("FAIL pixel (%0d,%0d): got rgb=%h%h%h on=%b want rgb=%h%h%h on=%b",
                 e.x, e.y, red, green, blue, sprite_on, e.r, e.g, e.b, e.on);
      end
    end
  end

  task automatic dchk(input int tag, input int x, input int y, input int act, input int exp);
    dir_t d;
    d.tag = tag; d.x = x; d.y = y; d.act = act; d.exp = exp;
    dq.push_back(d);
  endtask

  task automatic drive(input int x, input int y);
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    bg_red   = 4'(x);
    bg_green = 4'(y);
    bg_blue  = 4'(x + y + 7);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge vga_clk);
      drive(700, 500);
    end
  endtask

  // Expected output: palette colour of the ROM index when opaque, else this pixel's bg.
  task automatic pix(input int x, input int y, input logic on);
    exp_t e;
    @(negedge vga_clk);
    drive(x, y);
    e.t = cyc + 2; e.x = x; e.y = y; e.on = on;
    if (on) begin
      e.r = rom_val; e.g = ~rom_val; e.b = rom_val + 4'd3;
    end else begin
      e.r = bg_red; e.g = bg_green; e.b = bg_blue;
    end
    sb.push_back(e);
  endtask

  task automatic addr(input int x, input int y, input int exp);
    @(negedge vga_clk);
    drive(x, y);
    #1;
    dchk(4, x, y, int'(rom_addr), exp);
  endtask

  task automatic fs(input int x, input int y, input logic fl, input logic ae);
    @(negedge vga_clk);
    pos_x = 10'(x); pos_y = 10'(y); flip_h = fl; anim_en = ae;
    frame_start = 1'b1;
    drive(700, 500);
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge vga_clk);
    dchk(0, 0, 0, int'(red), 0);
    dchk(1, 0, 0, int'(green), 0);
    dchk(2, 0, 0, int'(blue), 0);
    dchk(3, 0, 0, int'(sprite_on), 0);
    reset = 1'b0;
    idle(2);

    // Placement and box edges (64x64 on screen at 100,50)
    fs(100, 50, 1'b0, 1'b0);
    pix(99, 50, 0);  pix(100, 50, 1); pix(163, 50, 1); pix(164, 50, 0);
    pix(100, 49, 0); pix(100, 113, 1); pix(100, 114, 0);

    // Address generation, flip, and zero address outside the box
    addr(103, 55, 65);
    addr(99, 50, 0);
    fs(100, 50, 1'b1, 1'b0);
    addr(103, 55, 94);
    fs(100, 50, 1'b0, 1'b0);

    // Transparency
    idle(2);
    rom_val = 4'd0;
    pix(110, 60, 0);
    idle(2);
    rom_val = 4'd5;
    idle(2);
    pix(110, 60, 1);

    // No tearing: pos_x change without frame_start is ignored
    @(negedge vga_clk);
    pos_x = 10'd300;
    pix(100, 50, 1); pix(300, 50, 0);
    fs(300, 50, 1'b0, 1'b0);
    pix(300, 50, 1); pix(100, 50, 0);

    // Clipping at the right edge
    fs(620, 0, 1'b0, 1'b0);
    pix(619, 10, 0); pix(620, 10, 1); pix(639, 10, 1); pix(0, 10, 0); pix(5, 10, 0);
    addr(639, 10, 169);

    // Animation: advance every 8 frame_starts, wrap after 32
    for (int i = 0; i < 7; i++) fs(100, 50, 1'b0, 1'b1);
    addr(103, 55, 65);
    fs(100, 50, 1'b0, 1'b1);
    addr(103, 55, 1089);
    pix(100, 50, 1);
    for (int i = 0; i < 8; i++) fs(100, 50, 1'b0, 1'b1);
    addr(103, 55, 2113);
    for (int i = 0; i < 8; i++) fs(100, 50, 1'b0, 1'b1);
    addr(103, 55, 3137);
    for (int i = 0; i < 8; i++) fs(100, 50, 1'b0, 1'b1);
    addr(103, 55, 65);
    for (int i = 0; i < 8; i++) fs(100, 50, 1'b0, 1'b0);
    addr(103, 55, 65);
    for (int i = 0; i < 8; i++) fs(100, 50, 1'b0, 1'b1);
    addr(103, 55, 1089);

    // Reset mid-line with an opaque pixel at the output
    idle(3);
    @(negedge vga_clk);
    drive(100, 50);
    @(posedge vga_clk);
    @(posedge vga_clk);
    #2;
    dchk(5, 100, 50, int'(sprite_on), 1);
    reset = 1'b1;
    #1;
    dchk(0, 100, 50, int'(red), 0);
    dchk(1, 100, 50, int'(green), 0);
    dchk(2, 100, 50, int'(blue), 0);
    dchk(3, 100, 50, int'(sprite_on), 0);
    drive(3, 5);
    #1;
    dchk(4, 3, 5, int'(rom_addr), 65);
    @(negedge vga_clk);
    reset = 1'b0;
    pix(0, 0, 1); pix(63, 63, 1); pix(64, 0, 0);

    idle(4);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite renderer for the VGA pixel pipeline: places a scaled, optionally mirrored, optionally animated sprite at a runtime position and composites it over a background colour, using colour-key transparency. It sits between the VGA controller (DrawX/DrawY) and the final RGB output register. It drives an external synchronous sprite ROM and an external combinational palette. It supersedes full-screen stretch rendering; this block adds positioning, clipping, integer scaling, flip, multi-frame animation and transparency.

## Interface
- SPRITE_W, 32: sprite width in texels.
- SPRITE_H, 32: sprite height in texels.
- FRAMES, 4: animation frames stored back-to-back in ROM (frame f at base f*SPRITE_W*SPRITE_H).
- SCALE_SHIFT, 1: on-screen scale of 2^SCALE_SHIFT pixels per texel per axis (0..3).
- IDX_W, 4: palette index width.
- TRANSPARENT_IDX, 0: index treated as transparent.
- ANIM_DIV, 8: video frames per animation step (≥1).
- ADDR_W, $clog2(FRAMES*SPRITE_W*SPRITE_H): ROM address width.
- vga_clk  in  1  pixel clock; all state on posedge.
- reset  in  1  asynchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of vertical blank; latches shadow registers.
- DrawX, DrawY  in  10 each  current pixel coordinates.
- pos_x, pos_y  in  10 each  requested sprite top-left; sampled only on frame_start.
- flip_h  in  1  requested horizontal mirror; sampled on frame_start.
- anim_en  in  1  animation advance enable; sampled on frame_start.
- bg_red, bg_green, bg_blue  in  4 each  background colour for the pixel at DrawX/DrawY.
- rom_addr  out  ADDR_W  combinational ROM address.
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_addr (ROM registers the address on posedge vga_clk).
- pal_index  out  IDX_W  equals rom_q.
- pal_red, pal_green, pal_blue  in  4 each  combinational palette result for pal_index.
- red, green, blue  out  4 each  registered composited colour.
- sprite_on  out  1  registered; 1 when the output pixel is an opaque sprite texel.

## Operation
- Shadow registers px, py (10 b), flip, and frame index fidx are updated only in the cycle of a frame_start pulse, so the sprite never tears within a frame.
- Animation: when frame_start is high and anim_en is high, the divider counter div increments. When div reaches ANIM_DIV-1, it clears to 0 and fidx advances, wrapping FRAMES-1 → 0. When anim_en is low at frame_start, div and fidx hold.
- Stage 0 (combinational, cycle t): compute dx = DrawX − px and dy = DrawY − py in 11-bit signed arithmetic. hit0 = dx ≥ 0 and dx < SPRITE_W<<SCALE_SHIFT and dy ≥ 0 and dy < SPRITE_H<<SCALE_SHIFT.
- Texel coordinates: lx = dx>>SCALE_SHIFT and ly = dy>>SCALE_SHIFT. When flip is set, lx' = SPRITE_W−1−lx; otherwise lx' = lx.
- rom_addr = fidx*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx'. When hit0 = 0, rom_addr is 0.
- Stage 1 register (edge t+1): hit1 ← hit0; bg colours are delayed by one stage.
- Output register (edge t+2):
  - opaque = hit1 and rom_q ≠ TRANSPARENT_IDX.
  - When opaque, red/green/blue ← pal_*. Otherwise they take the delayed bg.
  - sprite_on ← opaque.
- Clipping: a sprite partly off the right or bottom edge of the screen renders only its visible part; no wrap to the left or top edge.

## Timing
- Latency: DrawX/DrawY/bg at cycle t produce red/green/blue/sprite_on after edge t+2, giving a fixed 2-cycle latency. Throughput is one pixel per clock with no stalls.
- Reset (asynchronous):
  - red, green, blue, sprite_on, hit1 and the bg delay regs clear to 0.
  - px, py, flip, fidx and div clear to 0.
  - rom_addr follows combinationally from the reset shadow state.
- frame_start asserted in the same cycle as a visible pixel takes effect for the next pixel; the pixel in flight completes with its old state.
- Reset asserted mid-line clears the pipeline within the same cycle. The first valid output is 2 cycles after reset is released.
- ANIM_DIV = 1: fidx advances on every frame_start with anim_en high.
- FRAMES = 1: fidx stays 0.

## Test plan
- Placement: pos_x=100, pos_y=50, SCALE_SHIFT=1, frame_start pulse → sprite_on is first 1 for DrawX=100, DrawY=50 at t+2. DrawX=99 and DrawX=164 show bg.
- Scale/address: DrawX=103, DrawY=55 with px=100, py=50, fidx=0 → rom_addr = 2*32+1 = 65. With flip_h=1 → rom_addr = 2*32+30 = 94.
- Transparency: ROM returns 0 inside the box → output equals the bg delayed 2 cycles and sprite_on = 0. ROM returns 5 → output equals pal_* for index 5.
- Animation: anim_en=1, ANIM_DIV=8, FRAMES=4 → fidx advances 0→1 after 8 frame_starts and wraps 3→0 after 32. rom_addr base becomes 1024 in frame 1. anim_en=0 holds fidx.
- Clipping/no tearing: pos_x=620 → only columns 620..639 render. Changing pos_x mid-frame without frame_start produces no change.
- Reset: assert reset mid-line → all outputs 0 immediately, fidx = 0. Valid pixels resume 2 cycles after release.
